sr_pair_decoder: RTL and testbench
==================================

// Module: sr_pair_decoder
// PURPOSE
//  Reader side of a cross-coupled NOR SR latch: samples the dual-rail pair (q, q1)
//  from an external/asynchronous latch into the clk domain. Synchronizes, filters
//  glitches and decodes the pair into a clean level with rise/fall event pulses.
//  Flags the forbidden pattern (both rails equal, e.g. r=s=1 gives q=q1=0).
//  Sits between any SR-latch-based input (switch debounce, async flag) and sync logic.
// PARAMETERS
//  STABLE_CYCLES  4   cycles a new pattern must persist before commit; legal 2..255
//  CNT_W          8   width of glitch counter (used only with SR_DEC_GLITCH_CNT_EN)
// PORTS
//  clk         input   1      rising-edge clock
//  rst         input   1      synchronous, active-high reset
//  q           input   1      latch true rail, asynchronous
//  q1          input   1      latch complement rail, asynchronous
//  level       output  1      committed decoded level (q rail)
//  rise        output  1      1-cycle pulse: level committed 0->1
//  fall        output  1      1-cycle pulse: level committed 1->0
//  invalid     output  1      high while committed pattern is forbidden (q==q1)
//  err         output  1      1-cycle pulse on commit into invalid
//  glitch_cnt  output  CNT_W  rejected-pattern count (only with SR_DEC_GLITCH_CNT_EN)
// BEHAVIOUR
//  - Sync: 2-flop synchronizer per rail; sampled pattern P={qs,q1s}. Rails are
//    synchronized independently; skew between them is absorbed by the filter.
//  - Codes: P=10 -> VALID1, P=01 -> VALID0, P=00/11 -> ILLEGAL.
//  - Committed code C = invalid ? ILLEGAL : (level ? VALID1 : VALID0).
//  - FSM states STABLE, CHECK; regs cand (2b), fcnt (8b).
//  - STABLE: code(P)!=C -> CHECK, cand<=P, fcnt<=1; else stay.
//  - CHECK, P==cand, fcnt==STABLE_CYCLES-1 -> commit, go STABLE, fcnt<=0:
//     cand valid: level<=cand[1], invalid<=0; rise/fall pulse only if level changed.
//     cand illegal (00 or 11): invalid<=1, err pulse, level held.
//  - CHECK, P==cand, not yet done -> fcnt<=fcnt+1.
//  - CHECK, P!=cand -> abort: STABLE, fcnt<=0, nothing committed; re-evaluated
//    next cycle. An abort into a different illegal pattern (00<->11) also aborts.
//  - Latency: input held from before edge 1 -> level/pulse registered on edge
//    STABLE_CYCLES+2 (edge 6 at default).
//  - Pulses rise/fall/err are registered, exactly 1 cycle, mutually exclusive.
//  - Reset (any state, incl. mid-CHECK): sync flops <= {0,1}, state STABLE,
//    cand<=01, fcnt<=0, level=0, rise=fall=invalid=err=0, glitch_cnt=0. No pulse
//    on reset release; first edge after reset sees reset-value pattern 01.
// CONFIGURATION
//  SR_DEC_GLITCH_CNT_EN defined: glitch_cnt port present; +1 on every CHECK abort;
//   saturates at 2**CNT_W-1; cleared only by rst.
//  Not defined: glitch_cnt port and counter absent; all other behaviour identical.
// TESTING
//  1 rst 2 cycles, q=0 q1=1 held 20 cycles -> level=0, no rise/fall/err, invalid=0.
//  2 from (1) set q=1 q1=0 held -> rise=1 for one cycle on edge 6, level=1 after.
//  3 from level=0: q=1 q1=0 for 2 cycles then back to 0/1 -> level stays 0, no
//    pulse, glitch_cnt=1 (with macro).
//  4 q=0 q1=0 held 10 cycles -> invalid=1, single err pulse, level held; then
//    q=1 q1=0 -> invalid=0 and rise pulse 6 edges later.
//  5 level=1, q=0 q1=0 held -> invalid=1; then back to q=1 q1=0 -> invalid=0,
//    level=1, no rise pulse.
//  6 rst asserted during CHECK (fcnt=2) -> next edge all outputs 0, no pulse.

Source files
------------

// File: rtl/sr_pair_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sr_pair_decoder
// Description : Reader side of a cross-coupled NOR SR latch. Brings the
//               dual-rail pair (q, q1) into the clk domain through per-rail
//               2-flop synchronizers. A persistence filter then requires a new
//               pattern to be seen for STABLE_CYCLES consecutive cycles before
//               it is committed. The committed pattern is decoded into a clean
//               level with registered rise/fall pulses. The forbidden pattern
//               (q == q1) is flagged on invalid, with a one-cycle err pulse on
//               entry.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   STABLE_CYCLES : cycles a new pattern must persist before commit (2..255)
//   CNT_W         : glitch counter width (used only with the option below)
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   q          in   1      latch true rail (asynchronous)
//   q1         in   1      latch complement rail (asynchronous)
//   level      out  1      committed decoded level (q rail)
//   rise       out  1      1-cycle pulse, level committed 0->1
//   fall       out  1      1-cycle pulse, level committed 1->0
//   invalid    out  1      committed pattern is forbidden (q == q1)
//   err        out  1      1-cycle pulse on commit into the forbidden pattern
//   glitch_cnt out  CNT_W  saturating count of rejected candidate patterns
// Compile-time option
//   SR_DEC_GLITCH_CNT_EN : when defined, adds glitch_cnt and its counter.
//                          When undefined, the port and counter are absent.
// ============================================================================
module sr_pair_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q,
    input  logic             q1,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic             invalid,
    output logic             err
`ifdef SR_DEC_GLITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] glitch_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------------
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || CNT_W < 1) begin : g_bad_params
        $error("sr_pair_decoder: STABLE_CYCLES must be 2..255 and CNT_W >= 1");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Pattern bit order is {q rail, q1 rail}; reset models a latch holding 0.
    localparam logic [1:0] c_rst_pat   = 2'b01;
    // The filter counter reaches this value on the last cycle before commit.
    localparam logic [7:0] c_fcnt_last = 8'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0] sync_meta_q, sync_meta_d;
    logic [1:0] sync_pat_q,  sync_pat_d;
    state_t     state_q,     state_d;
    logic [1:0] cand_q,      cand_d;
    logic [7:0] fcnt_q,      fcnt_d;
    logic       level_q,     level_d;
    logic       invalid_q,   invalid_d;
    logic       rise_q,      rise_d;
    logic       fall_q,      fall_d;
    logic       err_q,       err_d;

    // ------------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------------
    logic [1:0] w_pat;
    logic       w_pat_legal;
    logic       w_pat_is_committed;
    logic       w_cand_legal;

    assign w_pat       = sync_pat_q;
    assign w_pat_legal = w_pat[1] ^ w_pat[0];
    // Both forbidden patterns (00 and 11) decode to the same ILLEGAL code, so
    // while invalid is committed any illegal pattern counts as "no change".
    assign w_pat_is_committed = invalid_q ? ~w_pat_legal
                                          : (w_pat == {level_q, ~level_q});
    assign w_cand_legal = cand_q[1] ^ cand_q[0];

    // ------------------------------------------------------------------------
    // Synchronizer next state: each rail is synchronized independently; any
    // skew between the rails shows up as a short-lived pattern that the
    // persistence filter rejects.
    // ------------------------------------------------------------------------
    always_comb begin
        sync_meta_d = {q, q1};
        sync_pat_d  = sync_meta_q;
    end

    // ------------------------------------------------------------------------
    // Filter FSM next state and registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        fcnt_d    = fcnt_q;
        level_d   = level_q;
        invalid_d = invalid_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_STABLE: begin
                // The cycle that detects a change counts as the first sighting.
                if (!w_pat_is_committed) begin
                    state_d = ST_CHECK;
                    cand_d  = w_pat;
                    fcnt_d  = 8'd1;
                end
            end

            ST_CHECK: begin
                if (w_pat == cand_q) begin
                    if (fcnt_q == c_fcnt_last) begin
                        state_d = ST_STABLE;
                        fcnt_d  = 8'd0;
                        if (w_cand_legal) begin
                            level_d   = cand_q[1];
                            invalid_d = 1'b0;
                            // Leaving invalid back to the same level is silent.
                            rise_d    =  cand_q[1] & ~level_q;
                            fall_d    = ~cand_q[1] &  level_q;
                        end else begin
                            invalid_d = 1'b1;
                            err_d     = 1'b1;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end else begin
                    // Abort without committing; the new pattern is examined
                    // afresh from STABLE on the following cycle.
                    state_d = ST_STABLE;
                    fcnt_d  = 8'd0;
                end
            end

            default: begin
                state_d = ST_STABLE;
                fcnt_d  = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_q <= c_rst_pat;
            sync_pat_q  <= c_rst_pat;
            state_q     <= ST_STABLE;
            cand_q      <= c_rst_pat;
            fcnt_q      <= 8'd0;
            level_q     <= 1'b0;
            invalid_q   <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_pat_q  <= sync_pat_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            fcnt_q      <= fcnt_d;
            level_q     <= level_d;
            invalid_q   <= invalid_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            err_q       <= err_d;
        end
    end

    assign level   = level_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign invalid = invalid_q;
    assign err     = err_q;

`ifdef SR_DEC_GLITCH_CNT_EN
    // ------------------------------------------------------------------------
    // Rejected-pattern counter: one count per filter abort, saturating.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] glitch_q, glitch_d;
    logic             w_abort;

    assign w_abort = (state_q == ST_CHECK) && (w_pat != cand_q);

    always_comb begin
        glitch_d = glitch_q;
        if (w_abort && (glitch_q != {CNT_W{1'b1}})) begin
            glitch_d = glitch_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr_pair_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_pair_decoder
// Description : Self-checking bench for sr_pair_decoder. A streak-based model
//               of the filter predicts every output on every cycle; directed
//               scenarios add hand-computed literal checks at fixed edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_pair_decoder;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 8;
    localparam int GLITCH_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic q   = 1'b0;
    logic q1  = 1'b1;
    logic level, rise, fall, invalid, err;
`ifdef SR_DEC_GLITCH_CNT_EN
    logic [CNT_W-1:0] glitch_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sr_pair_decoder #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q          (q),
        .q1         (q1),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .invalid    (invalid),
        .err        (err)
`ifdef SR_DEC_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    // ------------------------------------------------------------------------
    // Model: a pattern must be seen STABLE_CYCLES times in a row (the first
    // sighting being the cycle it differs from what is committed) to commit.
    // A broken streak is a glitch; the breaking pattern starts no streak on
    // that same cycle.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic       level;
        logic       invalid;
        logic       rise;
        logic       fall;
        logic       err;
        logic [1:0] pat;
        int         len;
        int         glitch;
    } mstate_t;

    localparam mstate_t M_RESET = '{level: 1'b0, invalid: 1'b0, rise: 1'b0,
                                    fall: 1'b0, err: 1'b0, pat: 2'b01,
                                    len: 0, glitch: 0};

    mstate_t    m;
    logic [1:0] m_s1, m_s2;
    bit         m_live = 1'b0;

    function automatic bit same_as_committed(mstate_t s, logic [1:0] p);
        bit legal;
        legal = (p == 2'b10) || (p == 2'b01);
        if (s.invalid) return !legal;
        return (p == 2'b10) ? (s.level == 1'b1) : ((p == 2'b01) && (s.level == 1'b0));
    endfunction

    function automatic mstate_t model_next(mstate_t s, logic [1:0] p);
        mstate_t n;
        n      = s;
        n.rise = 1'b0;
        n.fall = 1'b0;
        n.err  = 1'b0;
        if (s.len == 0) begin
            if (!same_as_committed(s, p)) begin
                n.pat = p;
                n.len = 1;
            end
        end else if (p == s.pat) begin
            n.len = s.len + 1;
            if (n.len == STABLE_CYCLES) begin
                n.len = 0;
                if (p == 2'b10 || p == 2'b01) begin
                    n.level   = p[1];
                    n.invalid = 1'b0;
                    n.rise    = (p[1] == 1'b1) && (s.level == 1'b0);
                    n.fall    = (p[1] == 1'b0) && (s.level == 1'b1);
                end else begin
                    n.invalid = 1'b1;
                    n.err     = 1'b1;
                end
            end
        end else begin
            n.len = 0;
            if (s.glitch < GLITCH_MAX) n.glitch = s.glitch + 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m_live <= 1'b1;
        if (rst) begin
            m_s1 <= 2'b01;
            m_s2 <= 2'b01;
            m    <= M_RESET;
        end else begin
            m_s1 <= {q, q1};
            m_s2 <= m_s1;
            m    <= model_next(m, m_s2);
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_level",   int'(level),   int'(m.level));
            check("cyc_rise",    int'(rise),    int'(m.rise));
            check("cyc_fall",    int'(fall),    int'(m.fall));
            check("cyc_invalid", int'(invalid), int'(m.invalid));
            check("cyc_err",     int'(err),     int'(m.err));
`ifdef SR_DEC_GLITCH_CNT_EN
            check("cyc_glitch",  int'(glitch_cnt), m.glitch);
`endif
        end
    end

    // Inputs change 2 time units after a rising edge, so "edge 1" of a new
    // value is the next rising edge.
    task automatic set_in(input logic a, input logic b);
        @(posedge clk);
        #2;
        q  = a;
        q1 = b;
    endtask

    task automatic after_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Hold patterns for a skew/abort sweep: {q, q1, cycles held}.
    typedef struct packed {
        logic a;
        logic b;
        int   hold;
    } vec_t;

    initial begin
        vec_t vecs [8];
        vecs[0] = '{a: 1'b1, b: 1'b1, hold: 2};   // 11 streak broken by 00
        vecs[1] = '{a: 1'b0, b: 1'b0, hold: 2};
        vecs[2] = '{a: 1'b1, b: 1'b1, hold: 7};   // 11 committed -> err
        vecs[3] = '{a: 1'b0, b: 1'b0, hold: 6};   // still illegal: no change
        vecs[4] = '{a: 1'b1, b: 1'b0, hold: 1};   // short legal blip
        vecs[5] = '{a: 1'b0, b: 1'b0, hold: 3};
        vecs[6] = '{a: 1'b1, b: 1'b1, hold: 1};   // skewed q1 release
        vecs[7] = '{a: 1'b1, b: 1'b0, hold: 8};   // commit 1 -> rise

        // 1: reset, idle pattern 01 held
        rst = 1'b1; q = 1'b0; q1 = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        after_edges(20);
        check("t1_level",   int'(level),   0);
        check("t1_invalid", int'(invalid), 0);
        check("t1_pulses",  int'({rise, fall, err}), 0);
        check("t1_model_level", int'(m.level), 0);

        // 2: 10 held -> rise on edge 6
        set_in(1'b1, 1'b0);
        after_edges(5);
        check("t2_rise_e5",  int'(rise),  0);
        check("t2_level_e5", int'(level), 0);
        after_edges(1);
        check("t2_rise_e6",  int'(rise),  1);
        check("t2_level_e6", int'(level), 1);
        check("t2_model_rise_e6", int'(m.rise), 1);
        after_edges(1);
        check("t2_rise_e7",  int'(rise),  0);
        check("t2_level_e7", int'(level), 1);

        // back to level 0 (fall on edge 6)
        set_in(1'b0, 1'b1);
        after_edges(6);
        check("fall_e6",  int'(fall),  1);
        check("level_e6", int'(level), 0);
        after_edges(2);

        // 3: two-cycle 10 blip is rejected
        set_in(1'b1, 1'b0);
        @(posedge clk);
        set_in(1'b0, 1'b1);
        after_edges(8);
        check("t3_level", int'(level), 0);
        check("t3_rise",  int'(rise),  0);
        check("t3_model_glitch", m.glitch, 1);
`ifdef SR_DEC_GLITCH_CNT_EN
        check("t3_glitch_cnt", int'(glitch_cnt), 1);
`endif

        // 4: 00 held -> invalid + single err, then 10 -> rise
        set_in(1'b0, 1'b0);
        after_edges(5);
        check("t4_err_e5",     int'(err),     0);
        check("t4_invalid_e5", int'(invalid), 0);
        after_edges(1);
        check("t4_err_e6",     int'(err),     1);
        check("t4_invalid_e6", int'(invalid), 1);
        check("t4_level_e6",   int'(level),   0);
        after_edges(1);
        check("t4_err_e7",     int'(err),     0);
        after_edges(8);
        check("t4_invalid_hold", int'(invalid), 1);
        check("t4_level_hold",   int'(level),   0);
        set_in(1'b1, 1'b0);
        after_edges(5);
        check("t4_rise_e5", int'(rise),    0);
        check("t4_inv_e5b", int'(invalid), 1);
        after_edges(1);
        check("t4_rise_e6",  int'(rise),    1);
        check("t4_inv_e6b",  int'(invalid), 0);
        check("t4_level_e6b", int'(level),  1);

        // 5: level 1 -> 00 -> back to 10, no rise
        set_in(1'b0, 1'b0);
        after_edges(6);
        check("t5_invalid", int'(invalid), 1);
        check("t5_err",     int'(err),     1);
        check("t5_level",   int'(level),   1);
        after_edges(4);
        set_in(1'b1, 1'b0);
        after_edges(6);
        check("t5_invalid_clr", int'(invalid), 0);
        check("t5_level_back",  int'(level),   1);
        check("t5_no_rise",     int'(rise),    0);
        after_edges(2);

        // 6: reset during CHECK with fcnt=2 (fall would have been pending)
        set_in(1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        after_edges(1);
        check("t6_level",   int'(level),   0);
        check("t6_pulses",  int'({rise, fall, err}), 0);
        check("t6_invalid", int'(invalid), 0);
`ifdef SR_DEC_GLITCH_CNT_EN
        check("t6_glitch_cnt", int'(glitch_cnt), 0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;
        after_edges(10);
        check("t6_level_after", int'(level), 0);

        // 7: illegal-to-illegal aborts, commit into 11, skewed rail release
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].a, vecs[i].b);
            if (vecs[i].hold > 1) repeat (vecs[i].hold - 1) @(posedge clk);
        end
        after_edges(4);
        check("t7_level",   int'(level),   1);
        check("t7_invalid", int'(invalid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
